cp0_irq_timer: RTL and testbench
================================

# cp0_irq_timer

Parametrised coprocessor-0 for the pipelined MIPS core, successor to the fixed six-line CP0. It holds the SR, Cause, EPC, PRId, BadVAddr, Count and Compare registers and takes a configurable number of hardware interrupt lines, each either level- or edge-sensitive. It adds a Count/Compare timer that raises its own interrupt. It sits beside the M stage, and its `int_req` drives the pipeline flush and handler redirect.

## Interface
- `NUM_HWINT`, 5: external interrupt lines (1..5); line i maps to Cause.IP/SR.IM bit 10+i.
- `EDGE_MASK`, 5'b0: per-line mode; 1 = rising-edge latched, 0 = level.
- `COUNT_DIV`, 2: Count increments once every COUNT_DIV cycles (≥1).
- `PRID_VALUE`, 32'd19373573: PRId read value.
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `rd_addr` in 5: mfc0 register number.
- `rd_data` out 32: combinational read data; 0 for unmapped numbers.
- `wr_addr` in 5: mtc0 register number.
- `wr_data` in 32: mtc0 data.
- `we` in 1: mtc0 strobe.
- `pc` in 32: PC of the M-stage instruction.
- `delay_slot` in 1: M-stage instruction is in a delay slot.
- `exc_code` in 5: pending exception code; 0 = none.
- `bad_vaddr` in 32: faulting address, captured for AdEL/AdES (codes 4/5).
- `eret` in 1: eret commits; clears EXL.
- `hw_int` in NUM_HWINT: external interrupt lines.
- `int_req` out 1: take interrupt or exception this cycle.
- `epc` out 32: EPC for eret redirect.
- `timer_irq` out 1: Cause.TI, the timer pending flag.

## Operation
- Register numbers: BadVAddr 8, Count 9, Compare 11, SR 12, Cause 13, EPC 14, PRId 15.
- SR fields:
  - IM[15:10] covers the lines; IM[15] masks the timer.
  - EXL[1], IE[0].
  - All other bits read 0.
- Cause fields: BD[31], TI[30], IP[15:10], ExcCode[6:2].
- IP[15] reads `TI | line5`.
- Level line: IP bit = `hw_int` registered each cycle.
- Edge line:
  - A rising edge (against the previous registered sample) sets the IP bit.
  - The bit stays set until an mtc0 to Cause writes 0 to it.
  - A set and a clear in the same cycle: set wins.
- Only edge-line IP bits are software-writable.
- Timer:
  - A divider counts 0..COUNT_DIV-1; Count+1 occurs on wrap.
  - When the incremented Count equals Compare, TI is set.
  - An mtc0 to Compare clears TI.
  - An mtc0 to Count loads Count and resets the divider. A load has priority over an increment.
- `intr` = `|(IP & IM) & IE & !EXL`.
- `int_req` = `intr | (exc_code != 0)`.
- Entry when `int_req` is high:
  - EXL <= 1.
  - BD <= `delay_slot`.
  - EPC <= word-aligned `pc`, minus 4 if `delay_slot`.
  - ExcCode <= 0 for an interrupt, otherwise `exc_code`.
  - An interrupt has priority over an exception.
  - BadVAddr <= `bad_vaddr` only on an exception entry with code 4 or 5.
- mtc0 EPC writes `wr_data` with bits [1:0] forced to 0.
- Simultaneous events:
  - Entry overrides a same-cycle mtc0 to SR.EXL/EPC.
  - `eret` with no entry clears EXL.
  - Entry and `eret` together: EXL = 1.

## Timing
- Reset values:
  - SR, Cause, EPC, BadVAddr, Count, divider: 0.
  - Compare = 32'hFFFF_FFFF.
  - Edge-sample flops: 0.
  - Hence `int_req`=0, `epc`=0, `timer_irq`=0.
- Reset mid-operation clears all state on the next edge, including pending edge latches and TI.
- `hw_int` reaches IP one cycle later; `int_req` asserts combinationally in that cycle if enabled.
- `rd_data` reflects state after the last edge; a same-cycle mtc0 becomes visible next cycle.
- Count wraps 32'hFFFF_FFFF → 0 with no flag. Compare match is evaluated on the increment only, not on a software load.

## Structure
- Shared package `cp0_defs`:
  - Register numbers.
  - ExcCode values (Int 0, AdEL 4, AdES 5, Syscall 8, RI 10, Ov 12).
  - SR/Cause bit positions.
- Sub-module `cp0_count_timer`:
  - Contains the divider, Count, Compare and TI.
  - Inputs: `we`, `wr_addr`, `wr_data`.
  - Outputs: `count`, `compare`, `ti`.

## Test plan
- Reset, then read all registers -> SR/Cause/EPC/Count = 0, Compare = FFFFFFFF, PRId = 19373573, `int_req`=0.
- SR=0x0000_0401, level `hw_int[0]`=1 for one cycle -> IP[10] set the next cycle, `int_req`=1; with pc=0x3004, delay_slot=1, entry gives EPC=0x3000, BD=1, EXL=1, ExcCode=0.
- Line 1 edge mode: pulse 1 cycle, then drop -> IP[11] stays 1; mtc0 Cause with bit 11=0 -> IP[11]=0; the same-cycle re-edge keeps it 1.
- COUNT_DIV=2, Compare=5, Count=0, SR=0x8001 -> TI rises after 10 cycles and `int_req`=1; mtc0 Compare -> TI=0.
- exc_code=4, bad_vaddr=0x1235, pc=0x3010, with an unmasked interrupt pending -> Int wins (ExcCode 0, BadVAddr unchanged); repeat without the interrupt -> ExcCode 4, BadVAddr 0x1235.
- EXL=1, then `eret` with exc_code=12 in the same cycle -> EXL stays 1 and ExcCode=12; `eret` alone -> EXL=0.

Source files
------------

// File: rtl/cp0_irq_timer_pkg.sv
// Shared CP0 definitions: register numbers, exception codes and
// SR/Cause bit positions used by the CP0 block and its timer.
package cp0_defs;

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_SR       = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;
    localparam logic [4:0] REG_PRID     = 5'd15;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_SYS  = 5'd8,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

    localparam int SR_IE     = 0;
    localparam int SR_EXL    = 1;
    localparam int IM_LO     = 10;
    localparam int IM_HI     = 15;
    localparam int CAUSE_TI  = 30;
    localparam int CAUSE_BD  = 31;
    localparam int EXC_LO    = 2;
    localparam int EXC_HI    = 6;

    // Address-error exceptions are the only ones that capture BadVAddr.
    function automatic logic is_addr_exc(input logic [4:0] code);
        return (code == EXC_ADEL) || (code == EXC_ADES);
    endfunction

endpackage

// File: rtl/cp0_irq_timer_if.sv
// mfc0/mtc0 access port plus the M-stage exception/redirect signals.
// master = pipeline side, slave = CP0.
interface cp0_irq_timer_if;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        we;
    logic [31:0] pc;
    logic        delay_slot;
    logic [4:0]  exc_code;
    logic [31:0] bad_vaddr;
    logic        eret;
    logic        int_req;
    logic [31:0] epc;

    modport master (
        output rd_addr, wr_addr, wr_data, we, pc, delay_slot,
               exc_code, bad_vaddr, eret,
        input  rd_data, int_req, epc
    );

    modport slave (
        input  rd_addr, wr_addr, wr_data, we, pc, delay_slot,
               exc_code, bad_vaddr, eret,
        output rd_data, int_req, epc
    );
endinterface

// File: rtl/cp0_irq_timer_count_timer.sv
// Count/Compare timer: a prescale divider advances Count, and TI is
// raised when an increment lands on Compare. Software loads of Count
// never raise TI; writing Compare acknowledges it.
module cp0_count_timer
    import cp0_defs::*;
#(
    parameter int COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);

    localparam int DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIV - 1);

    logic [DIV_W-1:0] div;
    logic [31:0]      count_inc;
    logic             ld_count;
    logic             ld_compare;
    logic             div_wrap;

    assign ld_count   = we && (wr_addr == REG_COUNT);
    assign ld_compare = we && (wr_addr == REG_COMPARE);
    assign div_wrap   = (div == DIV_LAST);
    assign count_inc  = count + 32'd1;

    // Divider, Count, Compare and TI; a Count load beats the increment,
    // and a Compare write clears TI even if a match lands that cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            div     <= '0;
            count   <= '0;
            compare <= 32'hFFFF_FFFF;
            ti      <= 1'b0;
        end else begin
            if (ld_count) begin
                count <= wr_data;
                div   <= '0;
            end else if (div_wrap) begin
                count <= count_inc;
                div   <= '0;
            end else begin
                div <= div + 1'b1;
            end

            if (ld_compare)
                compare <= wr_data;

            if (ld_compare)
                ti <= 1'b0;
            else if (!ld_count && div_wrap && (count_inc == compare))
                ti <= 1'b1;
        end
    end

endmodule

// File: rtl/cp0_irq_timer.sv
// Coprocessor 0 with configurable level/edge hardware interrupt lines
// and a Count/Compare timer interrupt on IP[15]. int_req is combinational
// so the M stage can flush and redirect in the same cycle.
module cp0_irq_timer
    import cp0_defs::*;
#(
    parameter int          NUM_HWINT  = 5,
    parameter logic [4:0]  EDGE_MASK  = 5'b0,
    parameter int          COUNT_DIV  = 2,
    parameter logic [31:0] PRID_VALUE = 32'd19373573
) (
    input  logic                 clk,
    input  logic                 reset,
    cp0_irq_timer_if.slave       bus,
    input  logic [NUM_HWINT-1:0] hw_int,
    output logic                 timer_irq
);

    logic [NUM_HWINT-1:0] hw_q;
    logic [NUM_HWINT-1:0] ip_edge;
    logic [5:0]           ip;
    logic [5:0]           sr_im;
    logic                 sr_exl;
    logic                 sr_ie;
    logic                 cause_bd;
    logic [4:0]           cause_exc;
    logic [31:0]          epc_q;
    logic [31:0]          badv_q;
    logic [31:0]          count;
    logic [31:0]          compare;
    logic                 ti;
    logic                 intr;
    logic                 int_req;
    logic                 wr_sr;
    logic                 wr_cause;
    logic                 wr_epc;
    logic [31:0]          epc_entry;

    cp0_count_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .we      (bus.we),
        .wr_addr (bus.wr_addr),
        .wr_data (bus.wr_data),
        .count   (count),
        .compare (compare),
        .ti      (ti)
    );

    assign wr_sr    = bus.we && (bus.wr_addr == REG_SR);
    assign wr_cause = bus.we && (bus.wr_addr == REG_CAUSE);
    assign wr_epc   = bus.we && (bus.wr_addr == REG_EPC);

    // Pending lines: level lines follow the sample, edge lines the latch;
    // the timer shares the top bit with line 5.
    always_comb begin
        ip = '0;
        for (int i = 0; i < NUM_HWINT; i++)
            ip[i] = EDGE_MASK[i] ? ip_edge[i] : hw_q[i];
        ip[5] = ip[5] | ti;
    end

    assign intr      = (|(ip & sr_im)) && sr_ie && !sr_exl;
    assign int_req   = intr || (bus.exc_code != 5'd0);
    assign epc_entry = (bus.pc & 32'hFFFF_FFFC) - (bus.delay_slot ? 32'd4 : 32'd0);

    assign bus.int_req = int_req;
    assign bus.epc     = epc_q;
    assign timer_irq   = ti;

    // Line sampling and edge latches; a new rising edge beats a clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            hw_q    <= '0;
            ip_edge <= '0;
        end else begin
            hw_q <= hw_int;
            for (int i = 0; i < NUM_HWINT; i++) begin
                if (!EDGE_MASK[i])
                    ip_edge[i] <= 1'b0;
                else if (hw_int[i] && !hw_q[i])
                    ip_edge[i] <= 1'b1;
                else if (wr_cause)
                    ip_edge[i] <= bus.wr_data[IM_LO + i];
            end
        end
    end

    // SR, Cause, EPC and BadVAddr; exception/interrupt entry overrides
    // software writes to EXL and EPC.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr_im     <= '0;
            sr_exl    <= 1'b0;
            sr_ie     <= 1'b0;
            cause_bd  <= 1'b0;
            cause_exc <= '0;
            epc_q     <= '0;
            badv_q    <= '0;
        end else begin
            if (wr_sr) begin
                sr_im <= bus.wr_data[IM_HI:IM_LO];
                sr_ie <= bus.wr_data[SR_IE];
            end

            if (int_req)
                sr_exl <= 1'b1;
            else if (bus.eret)
                sr_exl <= 1'b0;
            else if (wr_sr)
                sr_exl <= bus.wr_data[SR_EXL];

            if (int_req) begin
                cause_bd  <= bus.delay_slot;
                epc_q     <= epc_entry;
                cause_exc <= intr ? EXC_INT : bus.exc_code;
                if (!intr && is_addr_exc(bus.exc_code))
                    badv_q <= bus.bad_vaddr;
            end else if (wr_epc) begin
                epc_q <= bus.wr_data & 32'hFFFF_FFFC;
            end
        end
    end

    // mfc0 read mux; unmapped register numbers read zero.
    always_comb begin
        bus.rd_data = '0;
        case (bus.rd_addr)
            REG_BADVADDR: bus.rd_data = badv_q;
            REG_COUNT:    bus.rd_data = count;
            REG_COMPARE:  bus.rd_data = compare;
            REG_SR:       bus.rd_data = {16'b0, sr_im, 8'b0, sr_exl, sr_ie};
            REG_CAUSE:    bus.rd_data = {cause_bd, ti, 14'b0, ip, 3'b0, cause_exc, 2'b0};
            REG_EPC:      bus.rd_data = epc_q;
            REG_PRID:     bus.rd_data = PRID_VALUE;
            default:      bus.rd_data = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_irq_timer.sv
// Bench for cp0_irq_timer: directed walk through the key behaviours,
// then a randomized run checked against a cycle-level reference model.
module tb_cp0_irq_timer;
    import cp0_defs::*;

    localparam int          NHW   = 5;
    localparam logic [4:0]  EMASK = 5'b00010;
    localparam int          CDIV  = 2;
    localparam logic [31:0] PRID  = 32'd19373573;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [NHW-1:0] hw_int = '0;
    logic           timer_irq;
    logic [31:0]    d;

    int checks = 0;
    int errors = 0;

    cp0_irq_timer_if bus();

    cp0_irq_timer #(
        .NUM_HWINT  (NHW),
        .EDGE_MASK  (EMASK),
        .COUNT_DIV  (CDIV),
        .PRID_VALUE (PRID)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.slave),
        .hw_int    (hw_int),
        .timer_irq (timer_irq)
    );

    always #5 clk = ~clk;

    // reference model state
    logic [5:0]  m_im;
    logic        m_ie, m_exl, m_bd, m_ti;
    logic [4:0]  m_exc;
    logic [31:0] m_epc, m_badv, m_base, m_compare;
    int unsigned m_ticks;
    logic [4:0]  m_prev, m_lat;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] v);
        bus.rd_addr = a;
        #1;
        v = bus.rd_data;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] v);
        bus.we      = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = v;
        tick();
        bus.we = 1'b0;
    endtask

    task automatic m_reset();
        m_im = '0; m_ie = 0; m_exl = 0; m_bd = 0; m_ti = 0; m_exc = '0;
        m_epc = '0; m_badv = '0; m_base = '0; m_compare = 32'hFFFF_FFFF;
        m_ticks = 0; m_prev = '0; m_lat = '0;
    endtask

    // Count is the last loaded value plus the number of whole divider periods since.
    function automatic logic [31:0] m_count();
        return m_base + 32'(m_ticks / CDIV);
    endfunction

    function automatic logic [5:0] m_ip();
        logic [5:0] r;
        r = '0;
        for (int i = 0; i < NHW; i++)
            r[i] = EMASK[i] ? m_lat[i] : m_prev[i];
        r[5] = r[5] | m_ti;
        return r;
    endfunction

    function automatic logic m_intr();
        return (|(m_ip() & m_im)) && m_ie && !m_exl;
    endfunction

    function automatic logic m_req();
        return m_intr() || (bus.exc_code != 5'd0);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd8:    return m_badv;
            5'd9:    return m_count();
            5'd11:   return m_compare;
            5'd12:   return (32'(m_im) << 10) | (32'(m_exl) << 1) | 32'(m_ie);
            5'd13:   return (32'(m_bd) << 31) | (32'(m_ti) << 30) | (32'(m_ip()) << 10) | (32'(m_exc) << 2);
            5'd14:   return m_epc;
            5'd15:   return PRID;
            default: return 32'd0;
        endcase
    endfunction

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        logic intr, req, s_sr, s_cause, s_epc, s_cnt, s_cmp;
        if (reset) begin
            m_reset();
            return;
        end
        intr    = m_intr();
        req     = intr || (bus.exc_code != 5'd0);
        s_sr    = bus.we && bus.wr_addr == 5'd12;
        s_cause = bus.we && bus.wr_addr == 5'd13;
        s_epc   = bus.we && bus.wr_addr == 5'd14;
        s_cnt   = bus.we && bus.wr_addr == 5'd9;
        s_cmp   = bus.we && bus.wr_addr == 5'd11;

        if (s_sr) begin
            m_im = bus.wr_data[15:10];
            m_ie = bus.wr_data[0];
        end
        if (req)           m_exl = 1'b1;
        else if (bus.eret) m_exl = 1'b0;
        else if (s_sr)     m_exl = bus.wr_data[1];

        if (req) begin
            m_bd  = bus.delay_slot;
            m_epc = (bus.pc & ~32'h3) - (bus.delay_slot ? 32'd4 : 32'd0);
            m_exc = intr ? 5'd0 : bus.exc_code;
            if (!intr && (bus.exc_code == 5'd4 || bus.exc_code == 5'd5))
                m_badv = bus.bad_vaddr;
        end else if (s_epc) begin
            m_epc = bus.wr_data & ~32'h3;
        end

        for (int i = 0; i < NHW; i++) begin
            if (EMASK[i]) begin
                if (hw_int[i] && !m_prev[i]) m_lat[i] = 1'b1;
                else if (s_cause)            m_lat[i] = bus.wr_data[10 + i];
            end
        end
        m_prev = hw_int;

        if (s_cnt) begin
            m_base  = bus.wr_data;
            m_ticks = 0;
        end else begin
            m_ticks++;
            if ((m_ticks % CDIV) == 0 && m_count() == m_compare && !s_cmp)
                m_ti = 1'b1;
        end
        if (s_cmp) begin
            m_compare = bus.wr_data;
            m_ti      = 1'b0;
        end
    endtask

    logic [4:0] addrs [8] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd3};
    logic [4:0] codes [6] = '{5'd4, 5'd5, 5'd8, 5'd10, 5'd12, 5'd4};

    initial begin
        bus.rd_addr = '0; bus.wr_addr = '0; bus.wr_data = '0; bus.we = 1'b0;
        bus.pc = '0; bus.delay_slot = 1'b0; bus.exc_code = '0;
        bus.bad_vaddr = '0; bus.eret = 1'b0;

        // reset values
        repeat (2) tick();
        reset = 1'b0;
        chk("rst_int_req", 32'(bus.int_req), 32'd0);
        chk("rst_timer_irq", 32'(timer_irq), 32'd0);
        chk("rst_epc_port", bus.epc, 32'd0);
        rd(REG_SR, d);       chk("rst_sr", d, 32'd0);
        rd(REG_CAUSE, d);    chk("rst_cause", d, 32'd0);
        rd(REG_EPC, d);      chk("rst_epc", d, 32'd0);
        rd(REG_COUNT, d);    chk("rst_count", d, 32'd0);
        rd(REG_COMPARE, d);  chk("rst_compare", d, 32'hFFFF_FFFF);
        rd(REG_PRID, d);     chk("rst_prid", d, 32'd19373573);
        rd(REG_BADVADDR, d); chk("rst_badv", d, 32'd0);

        // level line 0 interrupt taken from a delay slot
        wr(REG_SR, 32'h0000_0401);
        bus.pc = 32'h3004; bus.delay_slot = 1'b1;
        hw_int = 5'b00001;
        tick();
        hw_int = '0;
        rd(REG_CAUSE, d);
        chk("lvl_ip10", d & 32'h400, 32'h400);
        chk("lvl_int_req", 32'(bus.int_req), 32'd1);
        tick();
        bus.delay_slot = 1'b0;
        chk("ent_epc", bus.epc, 32'h3000);
        rd(REG_CAUSE, d); chk("ent_cause", d, 32'h8000_0000);
        rd(REG_SR, d);    chk("ent_sr", d, 32'h0000_0403);
        chk("ent_int_req_low", 32'(bus.int_req), 32'd0);
        wr(REG_SR, 32'd0);

        // edge line 1: latch, software clear, set beats clear
        hw_int = 5'b00010; tick();
        hw_int = '0;       tick();
        rd(REG_CAUSE, d); chk("edge_hold", d & 32'h800, 32'h800);
        wr(REG_CAUSE, 32'd0);
        rd(REG_CAUSE, d); chk("edge_clear", d & 32'h800, 32'h0);
        hw_int = 5'b00010;
        wr(REG_CAUSE, 32'd0);
        hw_int = '0;
        rd(REG_CAUSE, d); chk("edge_set_wins", d & 32'h800, 32'h800);
        wr(REG_CAUSE, 32'd0);

        // timer: Compare=5, Count=0, divide by 2 -> TI after 10 cycles
        wr(REG_COMPARE, 32'd5);
        wr(REG_SR, 32'h0000_8001);
        wr(REG_COUNT, 32'd0);
        repeat (9) tick();
        chk("tmr_not_yet", 32'(timer_irq), 32'd0);
        tick();
        chk("tmr_ti", 32'(timer_irq), 32'd1);
        chk("tmr_int_req", 32'(bus.int_req), 32'd1);
        rd(REG_COUNT, d); chk("tmr_count", d, 32'd5);
        wr(REG_COMPARE, 32'hFFFF_FFFF);
        chk("tmr_ack", 32'(timer_irq), 32'd0);
        wr(REG_SR, 32'd0);

        // interrupt beats an address-error exception
        wr(REG_SR, 32'h0000_0401);
        hw_int = 5'b00001; tick();
        bus.exc_code = 5'd4; bus.bad_vaddr = 32'h1235; bus.pc = 32'h3010;
        tick();
        bus.exc_code = '0; hw_int = '0;
        rd(REG_CAUSE, d);    chk("pri_exccode", (d >> 2) & 32'h1F, 32'd0);
        rd(REG_BADVADDR, d); chk("pri_badv", d, 32'd0);
        chk("pri_epc", bus.epc, 32'h3010);
        tick();
        wr(REG_SR, 32'h0000_0401);
        bus.exc_code = 5'd4;
        #1;
        chk("exc_int_req", 32'(bus.int_req), 32'd1);
        tick();
        bus.exc_code = '0;
        rd(REG_CAUSE, d);    chk("exc_exccode", (d >> 2) & 32'h1F, 32'd4);
        rd(REG_BADVADDR, d); chk("exc_badv", d, 32'h1235);

        // eret with a same-cycle exception keeps EXL
        bus.exc_code = 5'd12; bus.eret = 1'b1;
        tick();
        bus.exc_code = '0; bus.eret = 1'b0;
        rd(REG_SR, d);       chk("eret_exl_kept", d & 32'h2, 32'h2);
        rd(REG_CAUSE, d);    chk("eret_exccode", (d >> 2) & 32'h1F, 32'd12);
        rd(REG_BADVADDR, d); chk("eret_badv", d, 32'h1235);
        bus.eret = 1'b1;
        tick();
        bus.eret = 1'b0;
        rd(REG_SR, d);       chk("eret_clear", d & 32'h2, 32'h0);

        // randomized run against the reference model
        reset = 1'b1;
        model_step();
        tick();
        reset = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            reset  = ($urandom_range(0, 299) == 0);
            hw_int = hw_int ^ (5'($urandom) & 5'($urandom) & 5'($urandom));
            bus.we = ($urandom_range(0, 3) == 0);
            bus.wr_addr = addrs[$urandom_range(0, 7)];
            bus.wr_data = $urandom;
            if (bus.wr_addr == REG_COMPARE)
                bus.wr_data = m_count() + 32'($urandom_range(1, 6));
            else if (bus.wr_addr == REG_COUNT && $urandom_range(0, 1) == 1)
                bus.wr_data = 32'hFFFF_FFFD;
            bus.exc_code   = ($urandom_range(0, 5) == 0) ? codes[$urandom_range(0, 5)] : 5'd0;
            bus.eret       = ($urandom_range(0, 7) == 0);
            bus.pc         = $urandom;
            bus.delay_slot = 1'($urandom_range(0, 1));
            bus.bad_vaddr  = $urandom;
            bus.rd_addr    = ($urandom_range(0, 3) != 0) ? addrs[$urandom_range(0, 7)] : 5'($urandom);
            #1;
            chk("rnd_rd_data", bus.rd_data, m_read(bus.rd_addr));
            chk("rnd_int_req", 32'(bus.int_req), 32'(m_req()));
            chk("rnd_epc", bus.epc, m_epc);
            chk("rnd_timer_irq", 32'(timer_irq), 32'(m_ti));
            model_step();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
